// File: rtl/sram_responder.sv
// ---------------------------------------------------------------------------
// sram_responder
//
// On-chip memory that answers the LC-3 active-low SRAM control bus. Reads are
// registered and take READ_LAT cycles from the first OE-low cycle to valid
// data. Writes are byte-masked and commit once per WE-low assertion. A
// side-band init port loads the memory while the CPU bus is idle.
//
// Ports:
//   Clk            system clock, all logic on the rising edge
//   Reset          synchronous reset, active low (memory contents kept)
//   Mem_CE/OE/WE   chip enable / output enable / write enable, active low
//   Mem_UB/LB      upper [15:8] / lower [7:0] byte lane enables, active low
//   ADDR           word address
//   Data_from_CPU  write data
//   Data_to_CPU    registered read data
//   Data_valid     Data_to_CPU holds data for the current read
//   Busy           read in progress, data not yet valid
//   Bus_err        one-cycle pulse on an illegal command or init collision
//   Init_we        init-port write strobe (full word)
//   Init_addr      init-port word address
//   Init_data      init-port write data
// ---------------------------------------------------------------------------
module sram_responder #(
    parameter int ADDR_W   = 20,
    parameter int DEPTH    = 256,
    parameter int READ_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mem_CE,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic              Mem_UB,
    input  logic              Mem_LB,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [15:0]       Data_from_CPU,
    output logic [15:0]       Data_to_CPU,
    output logic              Data_valid,
    output logic              Busy,
    output logic              Bus_err,
    input  logic              Init_we,
    input  logic [ADDR_W-1:0] Init_addr,
    input  logic [15:0]       Init_data
);

    localparam int IDX_W = $clog2(DEPTH);
    // Wait counter holds READ_LAT-2, at most 6.
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 2);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_VALID = 2'd2,
        WR_HOLD  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic              rd_ok_q, rd_ok_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic [15:0]       mem [DEPTH];

    // Memory write port shared by CPU writes and init writes (never both).
    logic [1:0]        wr_be;
    logic [IDX_W-1:0]  wr_idx;
    logic [15:0]       wr_data;

    // Read load source: live ADDR on the IDLE edge, latched address later.
    logic              load_rd;
    logic [IDX_W-1:0]  src_idx;
    logic              src_ok;
    logic [15:0]       src_word;

    logic cmd_read, cmd_write, cmd_illegal;
    logic addr_ok, init_ok;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        // Extra bit keeps the compare correct even when DEPTH == 2**ADDR_W.
        return {1'b0, a} < (ADDR_W + 1)'(DEPTH);
    endfunction

    assign cmd_read    = !Mem_CE && !Mem_OE &&  Mem_WE;
    assign cmd_write   = !Mem_CE && !Mem_WE;
    assign cmd_illegal = !Mem_CE && !Mem_OE && !Mem_WE;
    assign addr_ok     = in_range(ADDR);
    assign init_ok     = in_range(Init_addr);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values; blocking = here would create order-dependent races.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // A write wins over a simultaneous OE-low (illegal command).
                if (cmd_write) begin
                    state_d = WR_HOLD;
                end else if (cmd_read) begin
                    state_d = (READ_LAT == 2) ? RD_VALID : RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (!cmd_read) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = RD_VALID;
                end
            end
            RD_VALID: begin
                if (!cmd_read) begin
                    state_d = IDLE;
                end
            end
            WR_HOLD: begin
                if (Mem_CE || Mem_WE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Output / datapath logic
    // ---------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        cnt_d    = cnt_q;
        rd_idx_d = rd_idx_q;
        rd_ok_d  = rd_ok_q;
        rdata_d  = rdata_q;
        // With READ_LAT == 2 the read goes straight to RD_VALID, so Busy is
        // never visible; data is already valid in the following cycle.
        valid_d  = (state_d == RD_VALID);
        busy_d   = (state_d == RD_WAIT);
        err_d    = 1'b0;
        wr_be    = 2'b00;
        wr_idx   = ADDR[IDX_W-1:0];
        wr_data  = Data_from_CPU;
        load_rd  = 1'b0;
        src_idx  = rd_idx_q;
        src_ok   = rd_ok_q;
        src_word = 16'h0000;

        case (state_q)
            IDLE: begin
                if (cmd_write) begin
                    // Out-of-range writes are dropped; WR_HOLD blocks repeats.
                    wr_be = addr_ok ? {~Mem_UB, ~Mem_LB} : 2'b00;
                    err_d = cmd_illegal;
                end else if (cmd_read) begin
                    rd_idx_d = ADDR[IDX_W-1:0];
                    rd_ok_d  = addr_ok;
                    cnt_d    = CNT_LOAD;
                    if (READ_LAT == 2) begin
                        load_rd = 1'b1;
                        src_idx = ADDR[IDX_W-1:0];
                        src_ok  = addr_ok;
                    end
                end else if (Init_we && Mem_CE) begin
                    wr_be   = init_ok ? 2'b11 : 2'b00;
                    wr_idx  = Init_addr[IDX_W-1:0];
                    wr_data = Init_data;
                end
            end
            RD_WAIT: begin
                if (cmd_read) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        load_rd = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // Init strobes are only honoured in IDLE with the chip deselected.
        if (Init_we && (!Mem_CE || state_q != IDLE)) begin
            err_d = 1'b1;
        end

        if (load_rd) begin
            src_word = src_ok ? mem[src_idx] : 16'h0000;
            rdata_d  = {Mem_UB ? 8'h00 : src_word[15:8],
                        Mem_LB ? 8'h00 : src_word[7:0]};
        end
    end

    // ---------------------------------------------------------------------
    // Output and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cnt_q    <= '0;
            rd_idx_q <= '0;
            rd_ok_q  <= 1'b0;
            rdata_q  <= 16'h0000;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rd_idx_q <= rd_idx_d;
            rd_ok_q  <= rd_ok_d;
            rdata_q  <= rdata_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    // ---------------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------------
    // NOTE: the array has no reset branch; contents survive Reset and the
    // array maps onto RAM. Reset only blocks writes while it is asserted.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            if (wr_be[1]) mem[wr_idx][15:8] <= wr_data[15:8];
            if (wr_be[0]) mem[wr_idx][7:0]  <= wr_data[7:0];
        end
    end

    assign Data_to_CPU = rdata_q;
    assign Data_valid  = valid_q;
    assign Busy        = busy_q;
    assign Bus_err     = err_q;

endmodule

// File: tb/tb_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_responder
//
// Drives one shared bus into two responders (READ_LAT = 2 and READ_LAT = 4).
// Expected read data is queued per instance when a read is issued and popped
// when that instance raises Data_valid. Cycle-exact corner cases are checked
// inline. Inputs change 1 ns after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_sram_responder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB;
    logic [19:0] ADDR;
    logic [15:0] Data_from_CPU;
    logic        Init_we;
    logic [19:0] Init_addr;
    logic [15:0] Init_data;

    logic [15:0] d2_data, d4_data;
    logic        d2_valid, d4_valid, d2_busy, d4_busy, d2_err, d4_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] q2[$];
    logic [15:0] q4[$];

    typedef struct packed {
        logic        wr;
        logic [19:0] addr;
        logic [15:0] data;
        logic        ub_n;
        logic        lb_n;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 Clk = ~Clk;

    sram_responder #(.ADDR_W(20), .DEPTH(256), .READ_LAT(2)) u_dut2 (
        .Clk(Clk), .Reset(Reset),
        .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
        .ADDR(ADDR), .Data_from_CPU(Data_from_CPU),
        .Data_to_CPU(d2_data), .Data_valid(d2_valid),
        .Busy(d2_busy), .Bus_err(d2_err),
        .Init_we(Init_we), .Init_addr(Init_addr), .Init_data(Init_data)
    );

    sram_responder #(.ADDR_W(20), .DEPTH(256), .READ_LAT(4)) u_dut4 (
        .Clk(Clk), .Reset(Reset),
        .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
        .ADDR(ADDR), .Data_from_CPU(Data_from_CPU),
        .Data_to_CPU(d4_data), .Data_valid(d4_valid),
        .Busy(d4_busy), .Bus_err(d4_err),
        .Init_we(Init_we), .Init_addr(Init_addr), .Init_data(Init_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: pop one expected word on each rising Data_valid.
    logic v2_prev = 1'b0;
    logic v4_prev = 1'b0;
    always @(negedge Clk) begin
        if (d2_valid === 1'b1 && v2_prev !== 1'b1) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_lat2: unexpected Data_valid, data=%h", d2_data);
            end else begin
                check("sb_lat2_data", d2_data, q2.pop_front());
            end
        end
        if (d4_valid === 1'b1 && v4_prev !== 1'b1) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_lat4: unexpected Data_valid, data=%h", d4_data);
            end else begin
                check("sb_lat4_data", d4_data, q4.pop_front());
            end
        end
        v2_prev = d2_valid;
        v4_prev = d4_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_idle();
        Mem_CE  = 1'b1;
        Mem_OE  = 1'b1;
        Mem_WE  = 1'b1;
        Mem_UB  = 1'b0;
        Mem_LB  = 1'b0;
        Init_we = 1'b0;
    endtask

    task automatic init_write(input logic [19:0] a, input logic [15:0] d);
        set_idle();
        Init_we   = 1'b1;
        Init_addr = a;
        Init_data = d;
        tick();
        Init_we   = 1'b0;
    endtask

    task automatic cpu_write(input logic [19:0] a, input logic [15:0] d,
                             input logic ub_n, input logic lb_n);
        Mem_CE = 1'b0; Mem_OE = 1'b1; Mem_WE = 1'b0;
        Mem_UB = ub_n; Mem_LB = lb_n;
        ADDR = a; Data_from_CPU = d;
        tick();
        set_idle();
        tick();
    endtask

    // n OE-low cycles; LAT2 needs 1 cycle for data, LAT4 needs 3.
    task automatic cpu_read(input logic [19:0] a, input logic ub_n, input logic lb_n,
                            input int n, input logic [15:0] exp);
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1;
        Mem_UB = ub_n; Mem_LB = lb_n;
        ADDR = a;
        q2.push_back(exp);
        if (n >= 3) q4.push_back(exp);
        repeat (n) tick();
        set_idle();
        tick();
    endtask

    initial begin
        // Table: writes first, then reads with constant expectations.
        vecs.push_back('{1'b1, 20'h00000, 16'h0001, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{1'b1, 20'h00030, 16'hDEAD, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{1'b1, 20'h00031, 16'hBEEF, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{1'b1, 20'h00031, 16'h1234, 1'b0, 1'b1, 16'h0000});
        vecs.push_back('{1'b1, 20'h00032, 16'hCAFE, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{1'b1, 20'h00032, 16'h0077, 1'b1, 1'b0, 16'h0000});
        vecs.push_back('{1'b1, 20'h00033, 16'h4444, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{1'b1, 20'h00033, 16'hFFFF, 1'b1, 1'b1, 16'h0000});
        vecs.push_back('{1'b1, 20'h000FF, 16'h0F0F, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{1'b1, 20'h00100, 16'h9999, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 20'h00030, 16'h0000, 1'b0, 1'b0, 16'hDEAD});
        vecs.push_back('{1'b0, 20'h00031, 16'h0000, 1'b0, 1'b0, 16'h12EF});
        vecs.push_back('{1'b0, 20'h00032, 16'h0000, 1'b0, 1'b0, 16'hCA77});
        vecs.push_back('{1'b0, 20'h00033, 16'h0000, 1'b0, 1'b0, 16'h4444});
        vecs.push_back('{1'b0, 20'h00030, 16'h0000, 1'b1, 1'b0, 16'h00AD});
        vecs.push_back('{1'b0, 20'h00030, 16'h0000, 1'b0, 1'b1, 16'hDE00});
        vecs.push_back('{1'b0, 20'h00030, 16'h0000, 1'b1, 1'b1, 16'h0000});
        vecs.push_back('{1'b0, 20'h000FF, 16'h0000, 1'b0, 1'b0, 16'h0F0F});
        vecs.push_back('{1'b0, 20'h00100, 16'h0000, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 20'h00000, 16'h0000, 1'b0, 1'b0, 16'h0001});

        set_idle();
        ADDR = '0; Data_from_CPU = '0; Init_addr = '0; Init_data = '0;

        // ---- Reset: two low cycles, then release ----
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(negedge Clk);
        check("rst_data2",  d2_data,  16'h0000);
        check("rst_valid2", d2_valid, 1'b0);
        check("rst_busy2",  d2_busy,  1'b0);
        check("rst_err2",   d2_err,   1'b0);
        check("rst_data4",  d4_data,  16'h0000);
        check("rst_valid4", d4_valid, 1'b0);
        check("rst_busy4",  d4_busy,  1'b0);
        check("rst_err4",   d4_err,   1'b0);
        tick();

        // ---- Init write, 2-cycle read: LAT2 completes, LAT4 aborts ----
        init_write(20'h00005, 16'h1234);
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1; ADDR = 20'h00005;
        q2.push_back(16'h1234);
        @(negedge Clk);                                   // cycle 0
        check("rd2_c0_valid", d2_valid, 1'b0);
        tick();
        @(negedge Clk);                                   // cycle 1
        check("rd2_c1_valid", d2_valid, 1'b1);
        check("rd2_c1_data",  d2_data,  16'h1234);
        check("rd2_c1_busy",  d2_busy,  1'b0);
        check("ab4_c1_busy",  d4_busy,  1'b1);
        check("ab4_c1_valid", d4_valid, 1'b0);
        tick();
        set_idle();                                       // cycle 2: OE high
        @(negedge Clk);
        check("ab4_c2_busy",  d4_busy,  1'b1);
        check("ab4_c2_valid", d4_valid, 1'b0);
        tick();
        @(negedge Clk);                                   // cycle 3
        check("rd2_c3_valid", d2_valid, 1'b0);
        check("rd2_c3_hold",  d2_data,  16'h1234);
        check("ab4_c3_busy",  d4_busy,  1'b0);
        check("ab4_c3_valid", d4_valid, 1'b0);
        check("ab4_c3_data",  d4_data,  16'h0000);
        tick();

        // ---- Full 4-cycle read on LAT4 ----
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1; ADDR = 20'h00005;
        q2.push_back(16'h1234);
        q4.push_back(16'h1234);
        @(negedge Clk);
        check("rd4_c0_busy", d4_busy, 1'b0);
        tick();
        @(negedge Clk);
        check("rd4_c1_busy", d4_busy, 1'b1);
        tick();
        @(negedge Clk);
        check("rd4_c2_busy",  d4_busy,  1'b1);
        check("rd4_c2_valid", d4_valid, 1'b0);
        tick();
        @(negedge Clk);
        check("rd4_c3_valid", d4_valid, 1'b1);
        check("rd4_c3_busy",  d4_busy,  1'b0);
        check("rd4_c3_data",  d4_data,  16'h1234);
        tick();
        set_idle();
        tick();

        // ---- Upper-byte write held 3 cycles: exactly one commit ----
        init_write(20'h00010, 16'h0000);
        Mem_CE = 1'b0; Mem_OE = 1'b1; Mem_WE = 1'b0;
        Mem_UB = 1'b0; Mem_LB = 1'b1;
        ADDR = 20'h00010; Data_from_CPU = 16'hABCD;
        tick();
        Data_from_CPU = 16'h1111;                         // must not commit
        tick();
        tick();
        set_idle();
        @(negedge Clk);
        check("wr_no_rdata2", d2_data, 16'h1234);
        check("wr_no_rdata4", d4_data, 16'h1234);
        tick();
        cpu_read(20'h00010, 1'b0, 1'b0, 4, 16'hAB00);

        // ---- Illegal CE/OE/WE all low: write wins, Bus_err pulses ----
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b0;
        ADDR = 20'h00020; Data_from_CPU = 16'h5555;
        @(negedge Clk);
        check("ill_c0_err2", d2_err, 1'b0);
        tick();
        set_idle();
        @(negedge Clk);
        check("ill_c1_err2", d2_err, 1'b1);
        check("ill_c1_err4", d4_err, 1'b1);
        tick();
        @(negedge Clk);
        check("ill_c2_err2", d2_err, 1'b0);
        check("ill_c2_err4", d4_err, 1'b0);

        // ---- Init strobe with CE low: ignored, Bus_err pulses ----
        Mem_CE = 1'b0; Init_we = 1'b1;
        Init_addr = 20'h00020; Init_data = 16'h7777;
        tick();
        set_idle();
        @(negedge Clk);
        check("init_ce_err2", d2_err, 1'b1);
        tick();
        @(negedge Clk);
        check("init_ce_err2_end", d2_err, 1'b0);
        cpu_read(20'h00020, 1'b0, 1'b0, 4, 16'h5555);

        // ---- Table-driven writes and reads ----
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr)
                cpu_write(vecs[i].addr, vecs[i].data, vecs[i].ub_n, vecs[i].lb_n);
            else
                cpu_read(vecs[i].addr, vecs[i].ub_n, vecs[i].lb_n, 4, vecs[i].exp);
        end

        // ---- Out-of-range address must not alias onto index 0 ----
        cpu_write(20'h00200, 16'h6666, 1'b0, 1'b0);
        cpu_read(20'h00200, 1'b0, 1'b0, 4, 16'h0000);
        cpu_read(20'h00000, 1'b0, 1'b0, 4, 16'h0001);

        // ---- Reset during RD_WAIT, memory preserved ----
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1; ADDR = 20'h00005;
        q2.push_back(16'h1234);
        tick();
        Reset = 1'b0;
        @(negedge Clk);
        check("rstw_c1_busy4", d4_busy, 1'b1);
        tick();
        Reset = 1'b1;
        set_idle();
        @(negedge Clk);
        check("rstw_busy4",  d4_busy,  1'b0);
        check("rstw_valid4", d4_valid, 1'b0);
        check("rstw_data4",  d4_data,  16'h0000);
        check("rstw_valid2", d2_valid, 1'b0);
        check("rstw_data2",  d2_data,  16'h0000);
        tick();
        cpu_read(20'h00005, 1'b0, 1'b0, 4, 16'h1234);
        cpu_read(20'h00010, 1'b0, 1'b0, 4, 16'hAB00);
        cpu_read(20'h00020, 1'b0, 1'b0, 4, 16'h5555);

        repeat (3) tick();
        check("sb_lat2_drained", q2.size(), 0);
        check("sb_lat4_drained", q4.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
